// File: rtl/demux_pkg.sv
// Shared constants and types for the 32-channel sequential byte demultiplexer.
// Channel count is tied to the 5-bit select/pointer width.
package demux_pkg;

    localparam int DW   = 8;
    localparam int NCH  = 32;
    localparam int SELW = 5;

    typedef logic [SELW-1:0] sel_t;

    localparam sel_t PTR_MAX = '1;

    typedef enum logic {
        MODE_ADDRESSED = 1'b0,
        MODE_AUTO_INC  = 1'b1
    } mode_e;

    // Modulo-32 advance of the auto-increment pointer; the wrap from 31 to 0
    // comes from the natural overflow of the 5-bit type.
    function automatic sel_t ptr_next(input sel_t p);
        return p + sel_t'(1);
    endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One output channel: a DW-bit data register and its valid flag.
// A write always wins over a same-cycle ack; an ack on an empty channel does nothing.
module demux_ch_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_ack,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [DW-1:0] r_data;
    logic          r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_data  <= i_wdata;
            r_valid <= 1'b1;
        end else if (i_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux_32bit_seq.sv
// Distributes a byte stream into 32 holding channels, addressed by sel or by an
// auto-incrementing pointer, with per-channel consume handshakes.
module demux_32bit_seq
    import demux_pkg::*;
#(
    parameter int DW  = demux_pkg::DW,
    parameter int NCH = demux_pkg::NCH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic               ptr_clr,
    output logic [NCH*DW-1:0]  out_data,
    output logic [NCH-1:0]     out_valid,
    input  logic [NCH-1:0]     out_ack,
    output logic [SELW-1:0]    ptr,
    output logic               wrap
);

    sel_t     r_ptr;
    logic     r_wrap;
    sel_t     w_target;
    logic     w_xfer;
    logic [NCH-1:0] w_valid;

    // NOTE: purely combinational signals use continuous assigns with every
    // input covered, so no latch can be inferred.
    assign w_target = (mode_e'(mode) == MODE_AUTO_INC) ? r_ptr : sel;
    assign in_ready = !w_valid[w_target] | out_ack[w_target];
    assign w_xfer   = in_valid & in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic w_wr;

        assign w_wr = w_xfer && (w_target == sel_t'(k));

        demux_ch_reg #(
            .DW (DW)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_wr    (w_wr),
            .i_wdata (in_data),
            .i_ack   (out_ack[k]),
            .o_data  (out_data[DW*k +: DW]),
            .o_valid (w_valid[k])
        );
    end

    // ptr_clr outranks the increment, so clearing at ptr=31 never pulses wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (ptr_clr) begin
                r_ptr <= '0;
            end else if (w_xfer && (mode_e'(mode) == MODE_AUTO_INC)) begin
                r_ptr  <= ptr_next(r_ptr);
                r_wrap <= (r_ptr == PTR_MAX);
            end
        end
    end

    assign out_valid = w_valid;
    assign ptr       = r_ptr;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_demux_32bit_seq.sv
// Directed self-checking bench for demux_32bit_seq: reset, addressed and
// auto-increment distribution, back-pressure, acks, pointer clear and wrap.
module tb_demux_32bit_seq;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [4:0]   sel;
    logic         ptr_clr;
    logic [255:0] out_data;
    logic [31:0]  out_valid;
    logic [31:0]  out_ack;
    logic [4:0]   ptr;
    logic         wrap;

    int checks   = 0;
    int failures = 0;

    demux_32bit_seq #(
        .DW  (8),
        .NCH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .ptr_clr   (ptr_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .ptr       (ptr),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chan(input logic [255:0] bus, input int k);
        return bus[k*8 +: 8];
    endfunction

    logic [255:0] exp_data;
    int           wrap_cnt;

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        mode     = 1'b0;
        sel      = '0;
        ptr_clr  = 1'b0;
        out_ack  = '0;
        step();
        step();

        // Reset state
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", out_data, 256'(0));
        check("rst_ptr", 256'(ptr), 256'(0));
        check("rst_wrap", 256'(wrap), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Addressed write to channel 5
        mode = 1'b0; sel = 5'd5; in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("addr_valid", 256'(out_valid), 256'(32'h0000_0020));
        check("addr_data", out_data, 256'h0A5 << 40);

        // Full channel back-pressures, then ack + write in the same cycle
        in_valid = 1'b1; in_data = 8'h3C;
        #1;
        check("stall_ready", 256'(in_ready), 256'(0));
        step();
        check("stall_hold", 256'(chan(out_data, 5)), 256'(8'hA5));
        check("stall_ptr", 256'(ptr), 256'(0));
        out_ack = 32'h0000_0020;
        #1;
        check("ackwr_ready", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0; out_ack = '0;
        check("ackwr_data", 256'(chan(out_data, 5)), 256'(8'h3C));
        check("ackwr_valid", 256'(out_valid), 256'(32'h0000_0020));
        check("ackwr_ptr_mode0", 256'(ptr), 256'(0));

        // Ack on an empty channel has no effect
        out_ack = 32'h0000_0008;
        step();
        check("ack_empty", 256'(out_valid), 256'(32'h0000_0020));

        // Ack on the full channel clears valid, keeps data
        out_ack = 32'h0000_0020;
        step();
        out_ack = '0;
        check("ack_clear_valid", 256'(out_valid), 256'(0));
        check("ack_keep_data", 256'(chan(out_data, 5)), 256'(8'h3C));

        // Auto-increment: 32 transfers fill channel k with k and wrap once
        mode = 1'b1; in_valid = 1'b1;
        wrap_cnt = 0;
        exp_data = '0;
        for (int i = 0; i < 32; i++) begin
            in_data = 8'(i);
            exp_data[i*8 +: 8] = 8'(i);
            step();
            if (wrap === 1'b1) wrap_cnt++;
        end
        in_valid = 1'b0;
        check("auto_data", out_data, exp_data);
        check("auto_valid", 256'(out_valid), 256'(32'hFFFF_FFFF));
        check("auto_ptr", 256'(ptr), 256'(0));
        check("auto_wrap_once", 256'(wrap_cnt), 256'(1));
        check("auto_wrap_last", 256'(wrap), 256'(1));
        step();
        check("auto_wrap_pulse", 256'(wrap), 256'(0));

        // Acking every channel at once
        out_ack = 32'hFFFF_FFFF;
        step();
        out_ack = '0;
        check("ackall_valid", 256'(out_valid), 256'(0));
        check("ackall_data", out_data, exp_data);

        // Advance ptr to 7, then ptr_clr alongside a transfer
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 8'hE0 + 8'(i);
            step();
        end
        check("pre_clr_ptr", 256'(ptr), 256'(7));
        ptr_clr = 1'b1; in_data = 8'h77;
        step();
        ptr_clr = 1'b0; in_valid = 1'b0;
        check("clr_ch7", 256'(chan(out_data, 7)), 256'(8'h77));
        check("clr_ch6", 256'(chan(out_data, 6)), 256'(8'hE6));
        check("clr_ptr", 256'(ptr), 256'(0));
        check("clr_no_wrap", 256'(wrap), 256'(0));
        check("clr_valid", 256'(out_valid), 256'(32'h0000_00FF));

        // Mode 1 stall at ptr=0 (channel 0 full)
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        check("m1_stall_ready", 256'(in_ready), 256'(0));
        step();
        check("m1_stall_ch0", 256'(chan(out_data, 0)), 256'(8'hE0));
        check("m1_stall_ptr", 256'(ptr), 256'(0));

        // Mode switch to addressed applies in the same cycle
        mode = 1'b0; sel = 5'd20; in_data = 8'h42;
        #1;
        check("m0_switch_ready", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0;
        check("m0_switch_ch20", 256'(chan(out_data, 20)), 256'(8'h42));
        check("m0_switch_ch0", 256'(chan(out_data, 0)), 256'(8'hE0));
        check("m0_switch_ptr", 256'(ptr), 256'(0));

        // Drain, advance ptr to 12, then reset during a transfer
        out_ack = 32'hFFFF_FFFF;
        step();
        out_ack = '0;
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'h10 + 8'(i);
            step();
        end
        check("pre_rst_ptr", 256'(ptr), 256'(12));
        rst_n = 1'b0; in_data = 8'hCC; ptr_clr = 1'b1; out_ack = 32'h0000_1001;
        step();
        rst_n = 1'b1; in_valid = 1'b0; ptr_clr = 1'b0; out_ack = '0;
        check("rst2_data", out_data, 256'(0));
        check("rst2_ch12", 256'(chan(out_data, 12)), 256'(0));
        check("rst2_valid", 256'(out_valid), 256'(0));
        check("rst2_ptr", 256'(ptr), 256'(0));
        check("rst2_wrap", 256'(wrap), 256'(0));
        check("rst2_ready", 256'(in_ready), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
